// File: rtl/mdu_if.sv
// Issue/result bus between the EX stage and the multiply/divide sequencer.
interface mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             flush;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b, flush,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, flush,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mdu_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer that borrows the EX-stage ALU and owns HI/LO.
// Optional MDU_DIVZERO_TRAP_EN: divide by zero finishes in one cycle with a div_zero pulse.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   S_IDLE   | waiting for start
//   S_PREP_A | signed only: |operand| held in acc_lo
//   S_PREP_B | signed only: |operand| held in opnd
//   S_ITER   | one shift-add / shift-subtract step per cycle
//   S_FIX_LO | signed only: sign fix of lo / quotient
//   S_FIX_HI | signed only: sign fix of hi / remainder
//   S_DONE   | HI/LO just committed, done pulse
module mdu_sequencer #(
    parameter int         WIDTH     = 32,
    parameter logic [3:0] ADDU_CODE = 4'b0000,
    parameter logic [3:0] SUBU_CODE = 4'b0001
) (
    input  logic             clk,
    input  logic             resetn,
    mdu_if.slave             m,
    output logic             alu_own,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_aluc,
    input  logic [WIDTH-1:0] alu_r,
    input  logic             alu_carry
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE, S_PREP_A, S_PREP_B, S_ITER, S_FIX_LO, S_FIX_HI, S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic             op_div, op_sgn, sign_lo, sign_op;
    logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
    logic [WIDTH-1:0] acc_hi_nxt, acc_lo_nxt, opnd_nxt;
    logic [WIDTH-1:0] hi_r, lo_r;
    logic [WIDTH-1:0] ld_lo, ld_op, rem_sh;
    logic             accept, dz_hit, neg, div_ok;

    // acc_lo starts as the multiplier or the dividend; opnd is the multiplicand or divisor
    assign ld_lo  = m.op[1] ? m.src_a : m.src_b;
    assign ld_op  = m.op[1] ? m.src_b : m.src_a;
    assign accept = (state == S_IDLE) && m.start && !m.flush;
    assign neg    = sign_lo ^ sign_op;
    assign rem_sh = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
    assign div_ok = !alu_carry || acc_hi[WIDTH-1];

`ifdef MDU_DIVZERO_TRAP_EN
    logic dz_r;

    assign dz_hit = m.op[1] && (m.src_b == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            dz_r <= 1'b0;
        else if (accept)
            dz_r <= dz_hit;
    end

    assign m.div_zero = (state == S_DONE) && dz_r;
`else
    assign dz_hit     = 1'b0;
    assign m.div_zero = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        alu_a     = '0;
        alu_b     = '0;
        alu_aluc  = ADDU_CODE;
        case (state)
            S_IDLE: begin
                if (accept)
                    state_nxt = dz_hit ? S_DONE : (m.op[0] ? S_PREP_A : S_ITER);
            end
            S_PREP_A: begin
                state_nxt = S_PREP_B;
                alu_b     = acc_lo;
                alu_aluc  = SUBU_CODE;
            end
            S_PREP_B: begin
                state_nxt = S_ITER;
                alu_b     = opnd;
                alu_aluc  = SUBU_CODE;
            end
            S_ITER: begin
                if (cnt == '0)
                    state_nxt = op_sgn ? S_FIX_LO : S_DONE;
                if (op_div) begin
                    alu_a    = rem_sh;
                    alu_b    = opnd;
                    alu_aluc = SUBU_CODE;
                end else begin
                    alu_a = acc_hi;
                    alu_b = acc_lo[0] ? opnd : '0;
                end
            end
            S_FIX_LO: begin
                state_nxt = S_FIX_HI;
                alu_b     = acc_lo;
                alu_aluc  = SUBU_CODE;
            end
            S_FIX_HI: begin
                state_nxt = S_DONE;
                if (op_div) begin
                    alu_b    = acc_hi;
                    alu_aluc = SUBU_CODE;
                end else begin
                    // 64-bit negate upper half: ~hi plus the carry out of 0 - lo
                    alu_a = ~acc_hi;
                    alu_b = {{(WIDTH-1){1'b0}}, (acc_lo == '0)};
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if ((state != S_IDLE) && m.flush)
            state_nxt = S_IDLE;
    end

    always_comb begin
        acc_hi_nxt = acc_hi;
        acc_lo_nxt = acc_lo;
        opnd_nxt   = opnd;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    acc_hi_nxt = '0;
                    acc_lo_nxt = ld_lo;
                    opnd_nxt   = ld_op;
                end
            end
            S_PREP_A: if (sign_lo) acc_lo_nxt = alu_r;
            S_PREP_B: if (sign_op) opnd_nxt = alu_r;
            S_ITER: begin
                if (op_div) begin
                    acc_hi_nxt = div_ok ? alu_r : rem_sh;
                    acc_lo_nxt = {acc_lo[WIDTH-2:0], div_ok};
                end else begin
                    acc_hi_nxt = {alu_carry, alu_r[WIDTH-1:1]};
                    acc_lo_nxt = {alu_r[0], acc_lo[WIDTH-1:1]};
                end
            end
            S_FIX_LO: if (neg) acc_lo_nxt = alu_r;
            // remainder follows the dividend's sign, the product follows the sign xor
            S_FIX_HI: if (op_div ? sign_lo : neg) acc_hi_nxt = alu_r;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_hi  <= '0;
            acc_lo  <= '0;
            opnd    <= '0;
            cnt     <= '0;
            op_div  <= 1'b0;
            op_sgn  <= 1'b0;
            sign_lo <= 1'b0;
            sign_op <= 1'b0;
            hi_r    <= '0;
            lo_r    <= '0;
        end else begin
            acc_hi <= acc_hi_nxt;
            acc_lo <= acc_lo_nxt;
            opnd   <= opnd_nxt;
            if (accept) begin
                op_div  <= m.op[1];
                op_sgn  <= m.op[0];
                sign_lo <= m.op[0] & ld_lo[WIDTH-1];
                sign_op <= m.op[0] & ld_op[WIDTH-1];
                cnt     <= CW'(WIDTH-1);
            end else if ((state == S_ITER) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            if ((state != S_IDLE) && (state_nxt == S_DONE)) begin
                hi_r <= acc_hi_nxt;
                lo_r <= acc_lo_nxt;
            end
        end
    end

    assign m.busy  = (state != S_IDLE);
    assign m.done  = (state == S_DONE);
    assign m.hi    = hi_r;
    assign m.lo    = lo_r;
    assign alu_own = (state != S_IDLE);
endmodule

// File: tb/tb_mdu_sequencer.sv
// Bench for mdu_sequencer: ALU stand-in, arithmetic reference model with per-cycle compare,
// and directed operations with literal expectations.
module tb_mdu_sequencer;
    localparam logic [3:0] ADDU = 4'b0000;
    localparam logic [3:0] SUBU = 4'b0001;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        alu_own;
    logic [31:0] alu_a, alu_b, alu_r;
    logic [3:0]  alu_aluc;
    logic        alu_carry;

    int total = 0;
    int bad   = 0;

    mdu_if #(.WIDTH(32)) bus();

    mdu_sequencer #(.WIDTH(32), .ADDU_CODE(ADDU), .SUBU_CODE(SUBU)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .m         (bus),
        .alu_own   (alu_own),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_aluc  (alu_aluc),
        .alu_r     (alu_r),
        .alu_carry (alu_carry)
    );

    always #5 clk = ~clk;

    // shared EX-stage ALU
    always_comb begin
        alu_r     = 32'h0;
        alu_carry = 1'b0;
        if (alu_aluc == SUBU) begin
            alu_r     = alu_a - alu_b;
            alu_carry = (alu_a < alu_b);
        end else begin
            {alu_carry, alu_r} = {1'b0, alu_a} + {1'b0, alu_b};
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, {31'h0, act}, {31'h0, exp});
    endtask

    // architectural result {hi, lo}
    function automatic logic [63:0] mdu_ref(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, q, r;
        logic [63:0] p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (op)
            2'b00: p = {32'h0, a} * {32'h0, b};
            2'b01: p = sa * sb;
            2'b10: p = (b == 32'h0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: begin
                if (b == 32'h0) begin
                    p = {a, (a[31] ? 32'h1 : 32'hFFFF_FFFF)};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
        endcase
        return p;
    endfunction

    // busy cycles from issue through the done cycle
    function automatic int mdu_lat(input logic [1:0] op, input logic [31:0] b);
`ifdef MDU_DIVZERO_TRAP_EN
        if (op[1] && (b == 32'h0)) return 1;
`endif
        return op[0] ? 37 : 33;
    endfunction

    int          m_left;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    logic        m_dz;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_left <= 0;
            m_hi   <= 32'h0;
            m_lo   <= 32'h0;
            m_dz   <= 1'b0;
            p_hi   <= 32'h0;
            p_lo   <= 32'h0;
        end else if (m_left != 0) begin
            if (bus.flush) begin
                m_left <= 0;
            end else begin
                m_left <= m_left - 1;
                if (m_left == 2) begin
                    m_hi <= p_hi;
                    m_lo <= p_lo;
                end
            end
        end else if (bus.start && !bus.flush) begin
            {p_hi, p_lo} <= mdu_ref(bus.op, bus.src_a, bus.src_b);
            m_left       <= mdu_lat(bus.op, bus.src_b);
`ifdef MDU_DIVZERO_TRAP_EN
            m_dz <= bus.op[1] && (bus.src_b == 32'h0);
`else
            m_dz <= 1'b0;
`endif
        end
    end

    always @(negedge clk) begin
        if (resetn) begin
            chk1("busy", bus.busy, m_left != 0);
            chk1("alu_own", alu_own, m_left != 0);
            chk1("done", bus.done, m_left == 1);
            chk1("div_zero", bus.div_zero, (m_left == 1) && m_dz);
            chk("hi", bus.hi, m_hi);
            chk("lo", bus.lo, m_lo);
            if (m_left == 0) begin
                chk("idle_alu_a", alu_a, 32'h0);
                chk("idle_alu_b", alu_b, 32'h0);
                chk("idle_aluc", {28'h0, alu_aluc}, {28'h0, ADDU});
            end
        end
    end

    task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e_hi, input logic [31:0] e_lo, input int e_cyc, input logic e_dz);
        int cyc;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.src_a = ~a;
        bus.src_b = ~b;
        cyc = 1;
        while (!bus.done && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk1({nm, "_done_seen"}, bus.done, 1'b1);
        chk({nm, "_cycle"}, cyc, e_cyc);
        chk({nm, "_hi"}, bus.hi, e_hi);
        chk({nm, "_lo"}, bus.lo, e_lo);
        chk1({nm, "_div_zero"}, bus.div_zero, e_dz);
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_done;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = 2'b00;
        bus.src_a = 32'h0;
        bus.src_b = 32'h0;
        #1 resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_done", bus.done, 1'b0);
        chk("rst_hi", bus.hi, 32'h0);
        chk("rst_lo", bus.lo, 32'h0);
        chk({28'h0, alu_aluc} == 32'h0 ? "rst_aluc" : "rst_aluc", {28'h0, alu_aluc}, {28'h0, ADDU});
        @(posedge clk); #1;

        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, 1'b0);
        run_op("mult_m3x7", 2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 37, 1'b0);
        run_op("div_m7d2", 2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 37, 1'b0);
        run_op("divu_64d7", 2'b10, 32'd64, 32'd7, 32'h0000_0001, 32'h0000_0009, 33, 1'b0);

        // flush mid-MULTU; a start while busy is ignored
        saw_done  = 1'b0;
        bus.op    = 2'b00;
        bus.src_a = 32'h1234_5678;
        bus.src_b = 32'h9ABC_DEF0;
        bus.start = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk); #1;
            bus.start = (c == 5);
            if (c == 5) begin
                bus.op    = 2'b10;
                bus.src_b = 32'h3;
            end
            bus.flush = (c == 10);
            if (bus.done) saw_done = 1'b1;
            if (c == 9) chk1("flush_busy_before", bus.busy, 1'b1);
            if (c == 11) chk1("flush_busy_after", bus.busy, 1'b0);
        end
        chk1("flush_no_done", saw_done, 1'b0);
        chk("flush_hi_kept", bus.hi, 32'h0000_0001);
        chk("flush_lo_kept", bus.lo, 32'h0000_0009);

        // start and flush together in IDLE: not accepted
        bus.op    = 2'b00;
        bus.src_a = 32'h5;
        bus.src_b = 32'h5;
        bus.start = 1'b1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        chk1("start_flush_busy", bus.busy, 1'b0);
        @(posedge clk); #1;

`ifdef MDU_DIVZERO_TRAP_EN
        run_op("divu_5d0", 2'b10, 32'h5, 32'h0, 32'h0000_0001, 32'h0000_0009, 1, 1'b1);
`else
        run_op("divu_5d0", 2'b10, 32'h5, 32'h0, 32'h0000_0005, 32'hFFFF_FFFF, 33, 1'b0);
`endif

        run_op("mult_min2", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 37, 1'b0);
        run_op("mult_lo0", 2'b01, 32'hFFFF_FFFC, 32'h4000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 37, 1'b0);
        run_op("mult_minx1", 2'b01, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 37, 1'b0);
        run_op("mult_m1m1", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 37, 1'b0);
        run_op("multu_x0", 2'b00, 32'h1234_5678, 32'h0, 32'h0, 32'h0, 33, 1'b0);
        run_op("multu_2p32", 2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 33, 1'b0);
        run_op("div_7dm2", 2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 37, 1'b0);
        run_op("div_m7dm2", 2'b11, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 37, 1'b0);
        run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 37, 1'b0);
        run_op("divu_maxd1", 2'b10, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'hFFFF_FFFF, 33, 1'b0);
        run_op("divu_small", 2'b10, 32'd100, 32'd200, 32'd100, 32'd0, 33, 1'b0);

        // reset in cycle 20 of a DIV
        bus.op    = 2'b11;
        bus.src_a = 32'hFFFF_FF9C;
        bus.src_b = 32'h7;
        bus.start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        chk1("pre_rst_busy", bus.busy, 1'b1);
        resetn = 1'b0;
        #1;
        chk1("midrst_busy", bus.busy, 1'b0);
        chk1("midrst_alu_own", alu_own, 1'b0);
        chk1("midrst_done", bus.done, 1'b0);
        chk1("midrst_div_zero", bus.div_zero, 1'b0);
        chk("midrst_hi", bus.hi, 32'h0);
        chk("midrst_lo", bus.lo, 32'h0);
        chk("midrst_alu_a", alu_a, 32'h0);
        chk("midrst_alu_b", alu_b, 32'h0);
        chk("midrst_aluc", {28'h0, alu_aluc}, {28'h0, ADDU});
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        run_op("post_rst_multu", 2'b00, 32'h3, 32'h5, 32'h0, 32'h0000_000F, 33, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
